// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl_pkg                                                       |
// | Shared pipeline types: stall-controller state encoding, zero register.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_load_use.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_use_detect                                                             |
// | Combinational load-use dependency check between ID/EX and IF/ID.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module load_use_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_uses_rs2,
    input  logic [4:0] i_rd,
    input  logic       i_memread,
    output logic       o_hit,
    output logic       o_match_a,
    output logic       o_match_b
);

    logic w_rd_live;

    assign w_rd_live = (i_rd != REG_ZERO);
    assign o_match_a = w_rd_live && (i_rd == i_rs1);
    assign o_match_b = w_rd_live && i_uses_rs2 && (i_rd == i_rs2);
    assign o_hit     = i_memread && (o_match_a || o_match_b);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl                                                           |
// | Pipeline stall/flush controller; optional stall counter under               |
// | HAZ_STALL_CNT_EN.                                                           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_ifid,
    input  logic [4:0]  rs2_ifid,
    input  logic        uses_rs2_ifid,
    input  logic [4:0]  rd_idex,
    input  logic        memread_idex,
    input  logic        memread_exmem,
    input  logic        mem_ready,
    input  logic        branch_taken_ex,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_hold,
    output logic        hazard_A_EXMEM,
    output logic        hazard_B_EXMEM
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    hz_state_t r_state;
    hz_state_t w_state_nxt;
    logic      w_hit;
    logic      w_match_a;
    logic      w_match_b;
    logic      w_mem_hold;
    logic      w_take_flush;
    logic      w_lu_stall;
    logic      r_haz_a;
    logic      r_haz_b;

    load_use_detect u_load_use_detect (
        .i_rs1      (rs1_ifid),
        .i_rs2      (rs2_ifid),
        .i_uses_rs2 (uses_rs2_ifid),
        .i_rd       (rd_idex),
        .i_memread  (memread_idex),
        .o_hit      (w_hit),
        .o_match_a  (w_match_a),
        .o_match_b  (w_match_b)
    );

    // A waiting load keeps the hold until mem_ready, even if memread_exmem drops.
    // The release cycle of MEM_WAIT behaves like RUN; only FLUSH masks events.
    assign w_mem_hold   = !mem_ready && (memread_exmem || (r_state == MEM_WAIT));
    assign w_take_flush = !w_mem_hold && (r_state != FLUSH) && branch_taken_ex;
    assign w_lu_stall   = !w_mem_hold && (r_state != FLUSH) && !branch_taken_ex && w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = RUN;
        if (w_mem_hold) begin
            w_state_nxt = MEM_WAIT;
        end else if (w_take_flush) begin
            w_state_nxt = FLUSH;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        if (rst) begin
            if (w_mem_hold) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                exmem_hold = 1'b1;
            end else if (w_take_flush) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (w_lu_stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // Flags capture at the stall, survive further stalls, drop after one free cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_haz_a <= 1'b0;
            r_haz_b <= 1'b0;
        end else if (w_lu_stall) begin
            r_haz_a <= w_match_a;
            r_haz_b <= w_match_b;
        end else if (pc_write) begin
            r_haz_a <= 1'b0;
            r_haz_b <= 1'b0;
        end
    end

    assign hazard_A_EXMEM = r_haz_a;
    assign hazard_B_EXMEM = r_haz_b;

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 32'd0;
        end else if (!pc_write && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_stall_ctrl                                                        |
// | Directed and random checks of hazard_stall_ctrl against a pipeline model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_ifid, rs2_ifid, rd_idex;
    logic        uses_rs2_ifid, memread_idex, memread_exmem, mem_ready, branch_taken_ex;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;
    logic        hazard_A_EXMEM, hazard_B_EXMEM;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model: what the pipeline is doing, in terms of pending events.
    bit          m_load_pending;
    bit          m_squashed;
    bit          m_fa, m_fb;
    logic [31:0] m_cnt;
    bit          e_pc, e_ifw, e_fl, e_bub, e_hold, e_lu, e_dep_a, e_dep_b;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_ifid        (rs1_ifid),
        .rs2_ifid        (rs2_ifid),
        .uses_rs2_ifid   (uses_rs2_ifid),
        .rd_idex         (rd_idex),
        .memread_idex    (memread_idex),
        .memread_exmem   (memread_exmem),
        .mem_ready       (mem_ready),
        .branch_taken_ex (branch_taken_ex),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_hold      (exmem_hold),
        .hazard_A_EXMEM  (hazard_A_EXMEM),
        .hazard_B_EXMEM  (hazard_B_EXMEM)
`ifdef HAZ_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit mem_busy, hit;
        if (!rst) begin
            m_load_pending = 0; m_squashed = 0; m_fa = 0; m_fb = 0; m_cnt = 32'd0;
            e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0; e_lu = 0;
            e_dep_a = 0; e_dep_b = 0;
        end else begin
            mem_busy = !mem_ready && (memread_exmem || m_load_pending);
            e_dep_a  = (rd_idex == rs1_ifid);
            e_dep_b  = uses_rs2_ifid && (rd_idex == rs2_ifid);
            hit      = memread_idex && (rd_idex != 5'd0) && (e_dep_a || e_dep_b);
            e_fl     = !mem_busy && !m_squashed && branch_taken_ex;
            e_lu     = !mem_busy && !m_squashed && !branch_taken_ex && hit;
            e_hold   = mem_busy;
            e_pc     = !(mem_busy || e_lu);
            e_ifw    = e_pc;
            e_bub    = e_fl || e_lu;
        end
    endtask

    task automatic model_commit();
        if (!rst) return;
        if (e_lu) begin
            m_fa = e_dep_a;
            m_fb = e_dep_b;
        end else if (e_pc) begin
            m_fa = 0;
            m_fb = 0;
        end
        if (!e_pc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        m_load_pending = e_hold;
        m_squashed     = e_fl;
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic step(input string tag);
        #1;
        model_eval();
        check_bit({tag, ".pc_write"},    pc_write,       e_pc);
        check_bit({tag, ".ifid_write"},  ifid_write,     e_ifw);
        check_bit({tag, ".ifid_flush"},  ifid_flush,     e_fl);
        check_bit({tag, ".idex_bubble"}, idex_bubble,    e_bub);
        check_bit({tag, ".exmem_hold"},  exmem_hold,     e_hold);
        check_bit({tag, ".flag_a"},      hazard_A_EXMEM, m_fa);
        check_bit({tag, ".flag_b"},      hazard_B_EXMEM, m_fb);
`ifdef HAZ_STALL_CNT_EN
        check_word({tag, ".stall_cnt"},  stall_cnt,      m_cnt);
`endif
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic quiet();
        rs1_ifid = 5'd0; rs2_ifid = 5'd0; rd_idex = 5'd0; uses_rs2_ifid = 1'b0;
        memread_idex = 1'b0; memread_exmem = 1'b0; mem_ready = 1'b1; branch_taken_ex = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        quiet();
        repeat (2) @(negedge clk);
        #1;
        check_bit("reset.pc_write", pc_write, 1'b1);
        check_bit("reset.exmem_hold", exmem_hold, 1'b0);
        check_bit("reset.flag_a", hazard_A_EXMEM, 1'b0);
        step("reset");
        rst = 1'b1;
        step("idle");

        // lw $5 in ID/EX, add reading $5 as rs1
        rd_idex = 5'd5; memread_idex = 1'b1; rs1_ifid = 5'd5; rs2_ifid = 5'd9; uses_rs2_ifid = 1'b1;
        #1;
        check_bit("lu5.stall_pc", pc_write, 1'b0);
        check_bit("lu5.stall_bubble", idex_bubble, 1'b1);
        step("lu5");
        memread_idex = 1'b0; rd_idex = 5'd0;
        #1;
        check_bit("lu5.next_flag_a", hazard_A_EXMEM, 1'b1);
        check_bit("lu5.next_flag_b", hazard_B_EXMEM, 1'b0);
        check_bit("lu5.next_pc", pc_write, 1'b1);
        step("lu5_next");
        #1;
        check_bit("lu5.clear_flag_a", hazard_A_EXMEM, 1'b0);

        // lw $0 never hazards
        rd_idex = 5'd0; memread_idex = 1'b1; rs1_ifid = 5'd0; rs2_ifid = 5'd0;
        #1;
        check_bit("lw0.pc", pc_write, 1'b1);
        step("lw0");
        check_bit("lw0.flag_a", hazard_A_EXMEM, 1'b0);
        check_bit("lw0.flag_b", hazard_B_EXMEM, 1'b0);

        // Three-cycle memory wait
        quiet();
        memread_exmem = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_bit("memw.hold", exmem_hold, 1'b1);
            check_bit("memw.pc", pc_write, 1'b0);
            step("memw");
        end
        mem_ready = 1'b1;
        #1;
        check_bit("memw.release_hold", exmem_hold, 1'b0);
        check_bit("memw.release_pc", pc_write, 1'b1);
        step("memw_rel");
        quiet();

        // Branch beats a coincident load-use hit; squashed hit ignored next cycle
        branch_taken_ex = 1'b1; rd_idex = 5'd5; memread_idex = 1'b1; rs1_ifid = 5'd5;
        #1;
        check_bit("br.flush", ifid_flush, 1'b1);
        check_bit("br.bubble", idex_bubble, 1'b1);
        check_bit("br.pc", pc_write, 1'b1);
        step("br");
        branch_taken_ex = 1'b0;
        #1;
        check_bit("br.squash_pc", pc_write, 1'b1);
        check_bit("br.squash_bubble", idex_bubble, 1'b0);
        step("br_squash");
        quiet();

        // Second load-use stall, dependency on rs2
        rd_idex = 5'd6; memread_idex = 1'b1; rs1_ifid = 5'd1; rs2_ifid = 5'd6; uses_rs2_ifid = 1'b1;
        step("lu6");
        memread_idex = 1'b0; rd_idex = 5'd0;
        #1;
        check_bit("lu6.flag_a", hazard_A_EXMEM, 1'b0);
        check_bit("lu6.flag_b", hazard_B_EXMEM, 1'b1);
`ifdef HAZ_STALL_CNT_EN
        check_word("cnt.five", stall_cnt, 32'd5);
`endif
        step("lu6_next");
        quiet();

        // Reset asserted in the middle of a memory wait
        memread_exmem = 1'b1; mem_ready = 1'b0;
        step("pre_rst");
        step("pre_rst");
        rst = 1'b0;
        #1;
        check_bit("rst_mid.hold", exmem_hold, 1'b0);
        check_bit("rst_mid.pc", pc_write, 1'b1);
        check_bit("rst_mid.ifid_write", ifid_write, 1'b1);
        step("rst_mid");
        quiet();
        rst = 1'b1;
        #1;
        check_bit("rst_rel.hold", exmem_hold, 1'b0);
        step("rst_rel");

`ifdef HAZ_STALL_CNT_EN
        dut.r_stall_cnt = 32'hFFFF_FFFD;
        m_cnt = 32'hFFFF_FFFD;
        memread_exmem = 1'b1; mem_ready = 1'b0;
        repeat (4) step("sat");
        check_word("cnt.saturate", stall_cnt, 32'hFFFF_FFFF);
        quiet();
        step("sat_rel");
`endif

        for (int i = 0; i < 400; i++) begin
            rs1_ifid        = 5'($urandom_range(0, 3));
            rs2_ifid        = 5'($urandom_range(0, 3));
            rd_idex         = 5'($urandom_range(0, 3));
            uses_rs2_ifid   = 1'($urandom_range(0, 1));
            memread_idex    = 1'($urandom_range(0, 1));
            memread_exmem   = ($urandom_range(0, 3) == 0);
            mem_ready       = ($urandom_range(0, 2) != 0);
            branch_taken_ex = ($urandom_range(0, 4) == 0);
            rst             = ($urandom_range(0, 79) != 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
